johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_decoder.sv | 161 ++++++++++++++++
 tb/tb_johnson_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder with HUNT/SYNC/LOCKED sequence tracking.
// Decodes each sample to a sequence index and flags out-of-order codes once locked.
module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2,
  localparam int IW      = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] jc_in,
  output logic [IW-1:0]    idx,
  output logic             legal,
  output logic             locked,
  output logic             seq_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [3:0]     run_q, run_d;
  logic [3:0]     miss_q, miss_d;
  logic [IW-1:0]  ref_q, ref_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           legal_q, legal_d;
  logic           locked_q, locked_d;
  logic           seq_err_q, seq_err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] inv_code;
  logic             code_legal;
  logic [IW-1:0]    code_idx;
  logic [IW-1:0]    succ;
  logic             is_succ;
  logic [3:0]       miss_inc;
  int               pop;

  // A legal code is a run of ones anchored at bit 0 (MSB clear) or at the MSB (MSB set).
  always_comb begin
    pop      = 0;
    inv_code = ~jc_in;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + int'(jc_in[i]);
    end
    if (jc_in[WIDTH-1]) begin
      code_legal = ((inv_code & (inv_code + WIDTH'(1))) == '0);
      code_idx   = IW'(2 * WIDTH - pop);
    end else begin
      code_legal = ((jc_in & (jc_in + WIDTH'(1))) == '0);
      code_idx   = IW'(pop);
    end
  end

  assign succ     = (ref_q == IW'(2 * WIDTH - 1)) ? '0 : ref_q + IW'(1);
  assign is_succ  = code_legal && (code_idx == succ);
  assign miss_inc = miss_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    miss_d    = miss_q;
    ref_d     = ref_q;
    idx_d     = idx_q;
    legal_d   = legal_q;
    err_cnt_d = err_cnt_q;
    seq_err_d = 1'b0;
    if (in_valid) begin
      legal_d = code_legal;
      if (code_legal) begin
        idx_d = code_idx;
      end
      case (state_q)
        HUNT: begin
          if (code_legal) begin
            ref_d = code_idx;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
              run_d   = 4'd0;
            end else begin
              state_d = SYNC;
              run_d   = 4'd1;
            end
          end
        end
        SYNC: begin
          if (!code_legal) begin
            state_d = HUNT;
            run_d   = 4'd0;
          end else begin
            ref_d = code_idx;
            // run counts the anchor sample, so lock lands after LOCK_CNT successors.
            if (!is_succ) begin
              run_d = 4'd1;
            end else if (run_q >= 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
              run_d   = 4'd0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (is_succ) begin
            miss_d = 4'd0;
            ref_d  = code_idx;
          end else begin
            seq_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
            // Illegal samples advance the reference as if the expected code arrived.
            ref_d = code_legal ? code_idx : succ;
            if (miss_inc >= 4'(MISS_MAX)) begin
              state_d = HUNT;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      run_q     <= 4'd0;
      miss_q    <= 4'd0;
      ref_q     <= '0;
      idx_q     <= '0;
      legal_q   <= 1'b0;
      locked_q  <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      legal_q   <= legal_d;
      locked_q  <= locked_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign idx     = idx_q;
  assign legal   = legal_q;
  assign locked  = locked_q;
  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - scoreboard bench for johnson_decoder against a table-driven model.
module tb_johnson_decoder;

  localparam int W        = 4;
  localparam int N        = 2 * W;
  localparam int IW       = 3;
  localparam int LOCK_CNT = 3;
  localparam int MISS_MAX = 2;
  localparam int M_HUNT = 0, M_SYNC = 1, M_LOCK = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  jc_in = '0;
  logic [IW-1:0] idx;
  logic          legal, locked, seq_err;
  logic [7:0]    err_cnt;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .jc_in(jc_in),
    .idx(idx), .legal(legal), .locked(locked), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int legal;
    int locked;
    int seq_err;
    int err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] jseq [N];
  int m_state, m_streak, m_miss, m_ref, m_idx, m_legal, m_err, m_seq_err;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [W-1:0] c);
    for (int i = 0; i < N; i++) if (jseq[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = M_HUNT; m_streak = 0; m_miss = 0; m_ref = 0;
    m_idx = 0; m_legal = 0; m_err = 0; m_seq_err = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] c);
    int k, nxt;
    m_seq_err = 0;
    if (!v) return;
    k = lookup(c);
    nxt = (m_ref + 1) % N;
    m_legal = (k >= 0);
    if (k >= 0) m_idx = k;
    if (m_state == M_HUNT) begin
      if (k >= 0) begin
        m_ref = k;
        m_streak = 0;
        m_miss = 0;
        m_state = (LOCK_CNT == 1) ? M_LOCK : M_SYNC;
      end
    end else if (m_state == M_SYNC) begin
      if (k < 0) m_state = M_HUNT;
      else begin
        m_streak = (k == nxt) ? m_streak + 1 : 0;
        m_ref = k;
        if (m_streak >= LOCK_CNT) begin
          m_state = M_LOCK;
          m_miss = 0;
        end
      end
    end else begin
      if (k == nxt) begin
        m_miss = 0;
        m_ref = k;
      end else begin
        m_seq_err = 1;
        if (m_err < 255) m_err++;
        m_miss++;
        m_ref = (k >= 0) ? k : nxt;
        if (m_miss >= MISS_MAX) m_state = M_HUNT;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] c);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    jc_in    = c;
    model_step(v, c);
    e.idx = m_idx; e.legal = m_legal; e.locked = (m_state == M_LOCK);
    e.seq_err = m_seq_err; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic feed_next();
    drive(1'b1, jseq[(m_ref + 1) % N]);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("idx", int'(idx), e.idx);
        chk("legal", int'(legal), e.legal);
        chk("locked", int'(locked), e.locked);
        chk("seq_err", int'(seq_err), e.seq_err);
        chk("err_cnt", int'(err_cnt), e.err);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] c;
    int r;
    c = '0;
    for (int i = 0; i < N; i++) begin
      jseq[i] = c;
      c = {c[W-2:0], ~c[W-1]};
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_idx", int'(idx), 0);
    chk("rst_legal", int'(legal), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;

    // clean lock
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b0001);
    drive(1'b1, 4'b0011);
    settle();
    chk("lock_early", int'(locked), 0);
    drive(1'b1, 4'b0111);
    settle();
    chk("lock_0111", int'(locked), 1);
    chk("lock_idx3", int'(idx), 3);
    drive(1'b1, 4'b1111);
    settle();
    chk("lock_idx4", int'(idx), 4);

    // wrap-around
    drive(1'b1, 4'b1110);
    drive(1'b1, 4'b1100);
    drive(1'b1, 4'b1000);
    drive(1'b1, 4'b0000);
    settle();
    chk("wrap_idx0", int'(idx), 0);
    drive(1'b1, 4'b0001);
    drive(1'b1, 4'b0011);
    settle();
    chk("wrap_err", int'(err_cnt), 0);

    // single glitch at idx 2
    drive(1'b1, 4'b0101);
    settle();
    chk("glitch_legal", int'(legal), 0);
    chk("glitch_seq_err", int'(seq_err), 1);
    chk("glitch_err", int'(err_cnt), 1);
    chk("glitch_idx_hold", int'(idx), 2);
    drive(1'b1, 4'b1111);
    settle();
    chk("glitch_recover_idx", int'(idx), 4);
    chk("glitch_recover_locked", int'(locked), 1);
    chk("glitch_recover_err", int'(seq_err), 0);

    // loss of lock
    for (int i = 0; i < 6; i++) feed_next();
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b1110);
    settle();
    chk("loss_locked", int'(locked), 0);
    chk("loss_err", int'(err_cnt), 3);

    // stall holds outputs
    for (int i = 0; i < 5; i++) drive(1'b0, W'($urandom));

    // relock, then saturate the error counter
    drive(1'b1, jseq[5]);
    for (int i = 0; i < LOCK_CNT; i++) feed_next();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b1010);
      feed_next();
    end
    settle();
    chk("sat_err", int'(err_cnt), 255);
    chk("sat_locked", int'(locked), 1);

    // asynchronous reset while locked with err_cnt=7
    sync_reset();
    drive(1'b1, jseq[6]);
    for (int i = 0; i < LOCK_CNT; i++) feed_next();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'b0110);
      feed_next();
    end
    settle();
    chk("pre_async_err", int'(err_cnt), 7);
    chk("pre_async_locked", int'(locked), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_err", int'(err_cnt), 0);
    chk("async_idx", int'(idx), 0);
    chk("async_legal", int'(legal), 0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12) drive(1'b0, W'($urandom));
      else if (r < 70) feed_next();
      else if (r < 85) drive(1'b1, jseq[$urandom_range(0, N - 1)]);
      else drive(1'b1, W'($urandom));
    end

    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
